// File: rtl/branch_predictor.sv
// branch_predictor: BHT-based next-PC predictor for a fetch stage.
// A request is captured in IDLE, looked up and decoded in LOOKUP, and
// presented with a one-cycle pred_valid pulse in RESP. Commit-time
// updates train a table of 2-bit saturating counters in any state.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a request; req_valid captures pc/ins
// LOOKUP | BHT read + opcode decode, prediction registered
// RESP   | pred_valid high for this single cycle, then back to IDLE
module branch_predictor #(
   parameter int BHT_INDEX_BITS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        req_valid,
   input  logic [31:0] req_pc,
   input  logic [31:0] req_ins,
   output logic        req_ready,
   output logic        pred_valid,
   output logic [31:0] pred_pc,
   output logic        pred_jump,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken
);

   localparam int         BHT_ENTRIES = 1 << BHT_INDEX_BITS;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [1:0] CTR_RESET   = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t                    state;
   state_t                    state_nxt;

   logic [31:0]               cap_pc;
   logic [31:0]               cap_ins;

   logic [1:0]                bht [BHT_ENTRIES];
   logic [BHT_INDEX_BITS-1:0] lk_idx;
   logic [BHT_INDEX_BITS-1:0] upd_idx;
   logic [1:0]                lk_ctr;
   logic [1:0]                upd_ctr;
   logic [1:0]                upd_ctr_nxt;

   logic [31:0]               j_imm;
   logic [31:0]               b_imm;
   logic [31:0]               pc_seq;
   logic [31:0]               pc_nxt;
   logic                      jump_nxt;

   logic                      unused_upd_pc;

   assign lk_idx  = cap_pc[BHT_INDEX_BITS+1:2];
   assign upd_idx = upd_pc[BHT_INDEX_BITS+1:2];
   assign lk_ctr  = bht[lk_idx];
   assign upd_ctr = bht[upd_idx];

   // only the index field of the commit address selects a counter
   assign unused_upd_pc = ^{upd_pc[31:BHT_INDEX_BITS+2], upd_pc[1:0]};

   assign req_ready  = (state == ST_IDLE);
   assign pred_valid = (state == ST_RESP);

   // state register; rdy low freezes the sequence
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else if (rdy) begin
         state <= state_nxt;
      end
   end

   // next-state logic; req_valid only matters in IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (req_valid) state_nxt = ST_LOOKUP;
         ST_LOOKUP: state_nxt = ST_RESP;
         ST_RESP:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // capture the request when it is accepted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_pc  <= '0;
         cap_ins <= '0;
      end else if (rdy && (state == ST_IDLE) && req_valid) begin
         cap_pc  <= req_pc;
         cap_ins <= req_ins;
      end
   end

   // immediate extraction and next-PC selection for the captured word
   always_comb begin
      j_imm    = {{11{cap_ins[31]}}, cap_ins[31], cap_ins[19:12],
                  cap_ins[20], cap_ins[30:21], 1'b0};
      b_imm    = {{19{cap_ins[31]}}, cap_ins[31], cap_ins[7],
                  cap_ins[30:25], cap_ins[11:8], 1'b0};
      pc_seq   = cap_pc + 32'd4;
      pc_nxt   = pc_seq;
      jump_nxt = 1'b0;
      case (cap_ins[6:0])
         OP_JAL: begin
            pc_nxt   = cap_pc + j_imm;
            jump_nxt = 1'b1;
         end
         OP_BRANCH: begin
            if (lk_ctr[1]) begin
               pc_nxt   = cap_pc + b_imm;
               jump_nxt = 1'b1;
            end
         end
         default: begin
            pc_nxt   = pc_seq;
            jump_nxt = 1'b0;
         end
      endcase
   end

   // prediction registers load in LOOKUP and hold everywhere else
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pred_pc   <= '0;
         pred_jump <= 1'b0;
      end else if (rdy && (state == ST_LOOKUP)) begin
         pred_pc   <= pc_nxt;
         pred_jump <= jump_nxt;
      end
   end

   // saturating step of the counter addressed by the commit
   always_comb begin
      upd_ctr_nxt = upd_ctr;
      if (upd_taken) begin
         if (upd_ctr != 2'b11) upd_ctr_nxt = upd_ctr + 2'd1;
      end else begin
         if (upd_ctr != 2'b00) upd_ctr_nxt = upd_ctr - 2'd1;
      end
   end

   // BHT write port; a same-cycle lookup already sampled the old value
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht[i] <= CTR_RESET;
         end
      end else if (rdy && upd_valid) begin
         bht[upd_idx] <= upd_ctr_nxt;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors and corner-case sequences for
// branch_predictor with hand-computed expected next-PC values.
module tb_branch_predictor;

   localparam logic [31:0] BEQ_M16 = 32'hFE0008E3;  // beq x0,x0,-16
   localparam logic [31:0] JAL_P8  = 32'h0080006F;  // jal x0,+8
   localparam logic [31:0] JAL_M4  = 32'hFFDFF06F;  // jal x0,-4
   localparam logic [31:0] JALR    = 32'h000080E7;  // jalr x1,0(x1)
   localparam logic [31:0] ADDI    = 32'h00000013;  // nop

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        req_valid;
   logic [31:0] req_pc;
   logic [31:0] req_ins;
   logic        req_ready;
   logic        pred_valid;
   logic [31:0] pred_pc;
   logic        pred_jump;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] ins;
      logic [31:0] exp_pc;
      logic        exp_jump;
   } vec_t;

   vec_t vecs [7];

   branch_predictor #(.BHT_INDEX_BITS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .req_valid  (req_valid),
      .req_pc     (req_pc),
      .req_ins    (req_ins),
      .req_ready  (req_ready),
      .pred_valid (pred_valid),
      .pred_pc    (pred_pc),
      .pred_jump  (pred_jump),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_taken  (upd_taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
   endtask

   task automatic upd(input logic [31:0] pc, input logic taken, input int n);
      repeat (n) begin
         upd_valid = 1'b1;
         upd_pc    = pc;
         upd_taken = taken;
         @(posedge clk); #1;
      end
      upd_valid = 1'b0;
   endtask

   // issue one request; optional rdy stall and taken-update during LOOKUP
   task automatic req_check(input string name, input logic [31:0] pc,
                            input logic [31:0] ins, input int stall,
                            input logic upd_lk, input logic [31:0] exp_pc,
                            input logic exp_jump);
      int          lat;
      logic [31:0] got_pc;
      logic        got_jump;
      check({name, " ready"}, {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_pc    = pc;
      req_ins   = ins;
      lat       = 0;
      @(posedge clk); #1;
      lat++;
      if (upd_lk) begin
         upd_valid = 1'b1;
         upd_pc    = pc;
         upd_taken = 1'b1;
      end
      if (stall > 0) begin
         rdy = 1'b0;
         repeat (stall) begin
            @(posedge clk); #1;
            lat++;
         end
         upd_valid = 1'b0;
         rdy       = 1'b1;
      end
      while (!pred_valid && lat < 12) begin
         @(posedge clk); #1;
         lat++;
         upd_valid = 1'b0;
      end
      got_pc    = pred_pc;
      got_jump  = pred_jump;
      req_valid = 1'b0;
      check({name, " latency"}, 32'(lat), 32'(2 + stall));
      check({name, " pred_pc"}, got_pc, exp_pc);
      check({name, " pred_jump"}, {31'b0, got_jump}, {31'b0, exp_jump});
      @(posedge clk); #1;
      check({name, " pulse width"}, {31'b0, pred_valid}, 32'd0);
      check({name, " pc hold"}, pred_pc, exp_pc);
   endtask

   initial begin
      logic seen;

      vecs[0] = '{"jal +8",       32'h0000_0100, JAL_P8,  32'h0000_0108, 1'b1};
      vecs[1] = '{"jal -4",       32'h0000_1000, JAL_M4,  32'h0000_0FFC, 1'b1};
      vecs[2] = '{"beq cold",     32'h0000_0200, BEQ_M16, 32'h0000_0204, 1'b0};
      vecs[3] = '{"jalr wrap",    32'hFFFF_FFFC, JALR,    32'h0000_0000, 1'b0};
      vecs[4] = '{"addi",         32'h0000_0300, ADDI,    32'h0000_0304, 1'b0};
      vecs[5] = '{"jal wrap",     32'hFFFF_FFFC, JAL_P8,  32'h0000_0004, 1'b1};
      vecs[6] = '{"beq cold 900", 32'h0000_0900, BEQ_M16, 32'h0000_0904, 1'b0};

      rst       = 1'b0;
      rdy       = 1'b1;
      req_valid = 1'b0;
      req_pc    = '0;
      req_ins   = '0;
      upd_valid = 1'b0;
      upd_pc    = '0;
      upd_taken = 1'b0;
      #12;
      check("reset req_ready", {31'b0, req_ready}, 32'd1);
      check("reset pred_valid", {31'b0, pred_valid}, 32'd0);
      check("reset pred_pc", pred_pc, 32'd0);
      check("reset pred_jump", {31'b0, pred_jump}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         req_check(vecs[i].name, vecs[i].pc, vecs[i].ins, 0, 1'b0,
                   vecs[i].exp_pc, vecs[i].exp_jump);
      end

      // 01 -> 11 after two taken commits
      upd(32'h0000_0200, 1'b1, 2);
      req_check("beq trained", 32'h0000_0200, BEQ_M16, 0, 1'b0,
                32'h0000_01F0, 1'b1);

      // saturate at 3: five taken then one not-taken leaves 2
      upd(32'h0000_0040, 1'b1, 5);
      upd(32'h0000_0040, 1'b0, 1);
      req_check("sat hi still taken", 32'h0000_0040, BEQ_M16, 0, 1'b0,
                32'h0000_0030, 1'b1);
      upd(32'h0000_0040, 1'b0, 1);
      req_check("sat hi now not", 32'h0000_0040, BEQ_M16, 0, 1'b0,
                32'h0000_0044, 1'b0);

      // saturate at 0: three not-taken then two taken gives 2
      upd(32'h0000_0080, 1'b0, 3);
      upd(32'h0000_0080, 1'b1, 2);
      req_check("sat lo", 32'h0000_0080, BEQ_M16, 0, 1'b0,
                32'h0000_0070, 1'b1);

      // same-cycle lookup/update: old value used, update still lands
      req_check("bypass old", 32'h0000_0500, BEQ_M16, 0, 1'b1,
                32'h0000_0504, 1'b0);
      req_check("bypass applied", 32'h0000_0500, BEQ_M16, 0, 1'b0,
                32'h0000_04F0, 1'b1);

      // rdy low for 3 cycles in LOOKUP with an update pending
      req_check("stall", 32'h0000_0700, BEQ_M16, 3, 1'b1,
                32'h0000_0704, 1'b0);
      req_check("stall upd dropped", 32'h0000_0700, BEQ_M16, 0, 1'b0,
                32'h0000_0704, 1'b0);

      // reset pulse during LOOKUP aborts the request and clears the BHT
      upd(32'h0000_0640, 1'b1, 2);
      req_valid = 1'b1;
      req_pc    = 32'h0000_0640;
      req_ins   = BEQ_M16;
      @(posedge clk); #1;
      check("pre-rst in lookup", {31'b0, req_ready}, 32'd0);
      rst = 1'b0;
      #1;
      check("mid-rst req_ready", {31'b0, req_ready}, 32'd1);
      check("mid-rst pred_valid", {31'b0, pred_valid}, 32'd0);
      check("mid-rst pred_pc", pred_pc, 32'd0);
      #1;
      rst       = 1'b1;
      req_valid = 1'b0;
      seen      = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (pred_valid) seen = 1'b1;
      end
      check("mid-rst no pulse", {31'b0, seen}, 32'd0);
      req_check("bht after rst", 32'h0000_0640, BEQ_M16, 0, 1'b0,
                32'h0000_0644, 1'b0);
      req_check("bht after rst 200", 32'h0000_0200, BEQ_M16, 0, 1'b0,
                32'h0000_0204, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: BHT_INDEX_BITS, default 8, log2 of BHT entry count; BHT index = pc[BHT_INDEX_BITS+1:2].
REQ-002 Ports: clk  in  1  single clock, all state on rising edge.
REQ-003 Ports: rst  in  1  reset, asynchronous, active-low.
REQ-004 Ports: rdy  in  1  global ready; low freezes all state.
REQ-005 Ports: req_valid  in  1  fetch stage requests a prediction; held high until pred_valid.
REQ-006 Ports: req_pc  in  32  address of the fetched instruction.
REQ-007 Ports: req_ins  in  32  fetched instruction word.
REQ-008 Ports: req_ready  out  1  high when idle and able to accept a request.
REQ-009 Ports: pred_valid  out  1  one-cycle pulse, prediction outputs valid.
REQ-010 Ports: pred_pc  out  32  predicted next PC.
REQ-011 Ports: pred_jump  out  1  1 = predicted taken/jump.
REQ-012 Ports: upd_valid  in  1  ROB commit of a conditional branch.
REQ-013 Ports: upd_pc  in  32  committed branch address.
REQ-014 Ports: upd_taken  in  1  actual branch outcome.

Function
REQ-015 BHT: 2^BHT_INDEX_BITS 2-bit saturating counters; counter >= 2 means taken.
REQ-016 FSM states IDLE, LOOKUP, RESP; req_ready = (state == IDLE).
REQ-017 IDLE: req_valid=1 -> capture req_pc and req_ins, go LOOKUP; else stay.
REQ-018 LOOKUP: read BHT at captured index, decode, compute pred_pc/pred_jump into output registers, go RESP.
REQ-019 RESP: pred_valid=1 for exactly this cycle, then IDLE; request-to-pulse latency is 2 cycles after acceptance edge.
REQ-020 Outputs pred_pc/pred_jump hold their last value outside RESP.
REQ-021 Decode opcode req_ins[6:0]: 1101111 (JAL) -> pred_pc = pc + J-imm (sign-extended, bit0=0), pred_jump=1.
REQ-022 Opcode 1100011 (branch): taken -> pred_pc = pc + B-imm (sign-extended, bit0=0), pred_jump=1; not taken -> pc+4, pred_jump=0.
REQ-023 All other opcodes, JALR included -> pred_pc = pc+4, pred_jump=0.
REQ-024 Address arithmetic is 32-bit modulo 2^32; wrap-around is not flagged.
REQ-025 Update: upd_valid=1 -> counter at upd_pc index +1 if upd_taken, -1 otherwise, saturating at 3 and 0.
REQ-026 Updates are processed in every state and never stall requests.
REQ-027 Same-cycle LOOKUP read and update to the same index: lookup uses the pre-update value; update still applies.
REQ-028 req_valid in LOOKUP/RESP is ignored; a request held high through RESP is re-accepted in the next IDLE cycle only if still asserted.
REQ-029 rdy=0: FSM, output registers and BHT unchanged, and upd_valid in that cycle is dropped; pred_valid held at its current value.

Reset
REQ-030 rst=0, asynchronously: state=IDLE, pred_valid=0, pred_pc=0, pred_jump=0, captured pc/ins=0.
REQ-031 rst=0: all BHT counters = 01 (weakly not taken).
REQ-032 Reset mid-request (LOOKUP/RESP) aborts the request; no pred_valid pulse follows; the requester re-issues it.

Verification
REQ-033 After reset, req_pc=0x100, req_ins=0x0080006F (JAL +8) -> pred_valid 2 cycles later, pred_pc=0x108, pred_jump=1.
REQ-034 Reset counters, BEQ at 0x200 offset -16 -> pred_pc=0x204, pred_jump=0; two upd_taken=1 for 0x200, then same request -> pred_pc=0x1F0, pred_jump=1.
REQ-035 Five upd_taken=1 then one upd_taken=0 at 0x40 -> counter 2, branch still predicted taken; a second upd_taken=0 -> not taken.
REQ-036 JALR 0x000080E7 at 0xFFFFFFFC -> pred_pc=0x00000000, pred_jump=0 (wrap).
REQ-037 rst pulsed low during LOOKUP -> no pred_valid pulse, req_ready=1 immediately, BHT back to 01.
REQ-038 rdy=0 for 3 cycles during LOOKUP with upd_valid asserted -> pulse delayed 3 cycles, counter unchanged.
